// File: rtl/arr_check_driver_if.sv
// Handshake bundle between arr_check_driver (master) and the array checker / bench (slave).
interface arr_check_driver_if #(
  parameter int LENGTH = 1
);
  logic              start;
  logic [31:0]       seed;
  logic              corrupt;
  logic              ack;
  logic [LENGTH-1:0] sig;
  logic [LENGTH-1:0] rfr;
  logic              check;
  logic              busy;
  logic              done;
  logic [15:0]       count;
  logic              timeout;

  modport master (
    input  start, seed, corrupt, ack,
    output sig, rfr, check, busy, done, count, timeout
  );

  modport slave (
    output start, seed, corrupt, ack,
    input  sig, rfr, check, busy, done, count, timeout
  );
endinterface

// File: rtl/arr_check_driver.sv
// LFSR-driven sig/rfr/check sequencer for the per-instance array checker.
// Optional ack timeout is compiled in with ARR_CHECK_DRIVER_TIMEOUT_EN.
module arr_check_driver #(
  parameter int LENGTH     = 1,
  parameter int NUM_CHECKS = 16,
  parameter int TIMEOUT    = 255
) (
  input logic                clk,
  input logic                rst_n,
  arr_check_driver_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARM, S_DONE} state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_lfsr;
  logic [LENGTH-1:0] r_sig;
  logic [LENGTH-1:0] r_rfr;
  logic              r_check;
  logic              r_done;
  logic [15:0]       r_count;
  logic              w_start;
  logic              w_load;
  logic              w_accept;
  logic              w_last;
  logic              w_tmo;
  logic              w_busy;

  if (LENGTH < 1 || LENGTH > 32 || NUM_CHECKS < 1 || NUM_CHECKS > 65535 || TIMEOUT < 1)
  begin : g_param_check
    $error("arr_check_driver: parameter out of legal range");
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (bus.start) w_state_nxt = S_LOAD;
      S_LOAD:         w_state_nxt = S_ARM;
      S_ARM: begin
        if (w_accept)   w_state_nxt = w_last ? S_DONE : S_LOAD;
        else if (w_tmo) w_state_nxt = S_DONE;
      end
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start  = 1'b0;
    w_load   = 1'b0;
    w_accept = 1'b0;
    w_busy   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: w_start = bus.start;
      S_LOAD: begin
        w_load = 1'b1;
        w_busy = 1'b1;
      end
      S_ARM: begin
        w_accept = bus.ack;
        w_busy   = 1'b1;
      end
      default: ;
    endcase
  end

  // count can never pass NUM_CHECKS: the last accepted vector exits to DONE
  assign w_last = ({1'b0, r_count} + 17'd1) == 17'(NUM_CHECKS);

`ifdef ARR_CHECK_DRIVER_TIMEOUT_EN
  logic [31:0] r_wait;
  logic        r_timeout;

  // an ack arriving on the final wait cycle wins over the timeout
  assign w_tmo = (r_state == S_ARM) && !bus.ack && (r_wait == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_load)                           r_wait <= '0;
      else if (r_state == S_ARM && !bus.ack) r_wait <= r_wait + 32'd1;
      if (w_start)    r_timeout <= 1'b0;
      else if (w_tmo) r_timeout <= 1'b1;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign w_tmo       = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= 32'd1;
      r_sig   <= '0;
      r_rfr   <= '0;
      r_check <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_start) begin
        r_lfsr  <= (bus.seed == 32'd0) ? 32'd1 : bus.seed;
        r_count <= '0;
        r_done  <= 1'b0;
      end
      if (w_load) begin
        r_sig   <= r_lfsr[LENGTH-1:0];
        r_rfr   <= bus.corrupt ? ~r_lfsr[LENGTH-1:0] : r_lfsr[LENGTH-1:0];
        r_lfsr  <= lfsr_step(r_lfsr);
        r_check <= 1'b1;
      end
      if (w_accept) begin
        r_check <= 1'b0;
        r_count <= r_count + 16'd1;
        if (w_last) r_done <= 1'b1;
      end else if (w_tmo) begin
        r_check <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign bus.sig   = r_sig;
  assign bus.rfr   = r_rfr;
  assign bus.check = r_check;
  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
  assign bus.count = r_count;
endmodule

// File: tb/tb_arr_check_driver.sv
// Self-checking bench for arr_check_driver (LENGTH=4, NUM_CHECKS=3, TIMEOUT=10).
// Timeout scenario is exercised when ARR_CHECK_DRIVER_TIMEOUT_EN is defined.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_arr_check_driver;
  localparam int NV = 3;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  logic [3:0] obs_sig [NV];

  arr_check_driver_if #(.LENGTH(4)) bus ();

  arr_check_driver #(
    .LENGTH(4),
    .NUM_CHECKS(NV),
    .TIMEOUT(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_step(input logic [31:0] v);
    logic [31:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic chk_zero(input string tag);
    logic [30:0] obs;
    obs = {bus.sig, bus.rfr, bus.check, bus.busy, bus.done, bus.count, bus.timeout};
    checks++;
    if (obs !== 31'h0) begin
      errors++;
      $error("FAIL %s reset-state: sig=%0h rfr=%0h check=%0b busy=%0b done=%0b count=%0h timeout=%0b",
             tag, bus.sig, bus.rfr, bus.check, bus.busy, bus.done, bus.count, bus.timeout);
    end
  endtask

  task automatic chk_wait(input string tag, input logic e_check, input logic e_tmo,
                          input logic e_done, input logic [15:0] e_count, input logic e_busy);
    checks++;
    if ({bus.check, bus.timeout, bus.done, bus.count, bus.busy} !==
        {e_check, e_tmo, e_done, e_count, e_busy}) begin
      errors++;
      $error("FAIL %s wait: check=%0b/%0b timeout=%0b/%0b done=%0b/%0b count=%0h/%0h busy=%0b/%0b",
             tag, bus.check, e_check, bus.timeout, e_tmo, bus.done, e_done,
             bus.count, e_count, bus.busy, e_busy);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run(input logic [31:0] sd, input int dmin, input int dmax,
                     input bit rcorr, input int cidx, input bit mid_start);
    logic [31:0] m;
    bit          corr [NV];
    logic [3:0]  es;
    logic [3:0]  er;
    int          d;
    m = (sd == 32'd0) ? 32'd1 : sd;
    for (int i = 0; i < NV; i++)
      corr[i] = rcorr ? ($urandom_range(1, 0) == 1) : (i == cidx);
    bus.seed    = sd;
    bus.start   = 1'b1;
    bus.corrupt = corr[0];
    edges = -1;
    tick();
    bus.start = 1'b0;
    bus.seed  = $urandom;
    `CHK("load_busy",  bus.busy,  1'b1)
    `CHK("load_check", bus.check, 1'b0)
    for (int i = 0; i < NV; i++) begin
      tick();
      es = m[3:0];
      er = corr[i] ? ~es : es;
      m  = ref_step(m);
      obs_sig[i] = bus.sig;
      `CHK("sig",        bus.sig,   es)
      `CHK("rfr",        bus.rfr,   er)
      `CHK("check_rise", bus.check, 1'b1)
      `CHK("count_arm",  bus.count, 16'(i))
      d = $urandom_range(dmax, dmin);
      if (d > 0) bus.ack = 1'b0;
      for (int k = 0; k < d; k++) begin
        bus.start = mid_start && (k == 1);
        tick();
        `CHK("hold_check", bus.check, 1'b1)
        `CHK("hold_sig",   bus.sig,   es)
        `CHK("hold_rfr",   bus.rfr,   er)
        `CHK("hold_count", bus.count, 16'(i))
        `CHK("hold_busy",  bus.busy,  1'b1)
      end
      bus.start   = 1'b0;
      bus.ack     = 1'b1;
      bus.corrupt = (i + 1 < NV) ? corr[i + 1] : 1'b0;
      tick();
      `CHK("ack_check", bus.check, 1'b0)
      `CHK("ack_count", bus.count, 16'(i + 1))
      `CHK("ack_done",  bus.done,  (i == NV - 1))
      `CHK("ack_busy",  bus.busy,  (i != NV - 1))
    end
    bus.ack = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.seed    = 32'd0;
    bus.corrupt = 1'b0;
    bus.ack     = 1'b0;
    #2;
    chk_zero("reset");
    do_reset();

    for (int k = 0; k < 5; k++) begin
      bus.ack     = $urandom_range(1, 0) == 1;
      bus.seed    = $urandom;
      bus.corrupt = $urandom_range(1, 0) == 1;
      tick();
      chk_zero("idle");
    end
    bus.ack = 1'b0;
    bus.corrupt = 1'b0;

    bus.ack = 1'b1;
    run(32'd1, 0, 0, 1'b0, -1, 1'b0);
    `CHK("done_edge", edges, 6)
    `CHK("seq0", obs_sig[0], 4'h1)
    `CHK("seq1", obs_sig[1], 4'h3)
    `CHK("seq2", obs_sig[2], 4'h2)
    tick();
    `CHK("done_hold_sig",  bus.sig,  4'h2)
    `CHK("done_hold_done", bus.done, 1'b1)

    bus.ack = 1'b1;
    run(32'd1, 0, 0, 1'b0, 1, 1'b0);

    run($urandom, 5, 5, 1'b0, -1, 1'b1);

    for (int r = 0; r < 6; r++) run($urandom, 0, 3, 1'b1, -1, 1'b0);

    bus.seed  = $urandom;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.ack = 1'b1;
    tick();
    tick();
    bus.ack = 1'b0;
    `CHK("pre_rst_check", bus.check, 1'b1)
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    tick();
    chk_zero("rst_hold");
    rst_n = 1'b1;
    tick();
    chk_zero("post_rst");
    run(32'd0, 0, 2, 1'b0, -1, 1'b0);
    `CHK("seed0_v0", obs_sig[0], 4'h1)
    `CHK("seed0_v1", obs_sig[1], 4'h3)
    `CHK("seed0_v2", obs_sig[2], 4'h2)

    bus.seed  = 32'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    tick();
`ifdef ARR_CHECK_DRIVER_TIMEOUT_EN
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_wait("tmo_wait", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    end
    tick();
    chk_wait("tmo_expired", 1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
    `CHK("tmo_check", bus.check,   1'b0)
    `CHK("tmo_flag",  bus.timeout, 1'b1)
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_wait("tmo_restart", 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
`else
    for (int k = 0; k < 20; k++) tick();
    chk_wait("wait_expired", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    `CHK("wait_check", bus.check,   1'b1)
    `CHK("wait_flag",  bus.timeout, 1'b0)
`endif
    do_reset();
    chk_zero("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
